mips_mem_arbiter: RTL and testbench

Sequencer that lets the Harvard MIPS core run from a single shared, multi-cycle memory port. Per instruction it fetches from `instr_address` and registers the word onto `instr_readdata`. It then performs the data access, if the core requests one, and latches the result. Finally it pulses `clk_enable` for one cycle so the core commits. It sits between `mips_cpu_harvard` and the unified memory/bus, replacing the ideal combinational instruction and data memories.

---
 rtl/mips_arb_pkg.sv | 18 +
 rtl/mips_arb_stats.sv | 28 ++
 rtl/mips_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mips_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_arb_pkg.sv
// Shared types and default widths for the MIPS shared-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_CNT_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    DATA,
    COMMIT
  } arb_state_t;

endpackage

// File: rtl/mips_arb_stats.sv
// Saturating stall and retired-instruction counters for the arbiter.
// Latency: counts appear one cycle after the increment strobe.
// Backpressure: none; counters stick at all-ones instead of wrapping.
module mips_arb_stats import mips_arb_pkg::*; #(
  parameter int CNT_W = ARB_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_stall,
  input  logic             inc_retire,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] instr_retired
);

  // Count strobes, holding at the maximum value once reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles  <= '0;
      instr_retired <= '0;
    end else begin
      if (inc_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (inc_retire && (instr_retired != '1))
        instr_retired <= instr_retired + 1'b1;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Sequences fetch, optional data access and a commit strobe for a Harvard MIPS core over one shared memory port.
// Latency: 3 cycles per ALU instruction, 4 per load/store, +1 per waitrequest cycle; IDLE->FETCH 1 cycle.
// Backpressure: mem_waitrequest holds the request stable and stretches FETCH/DATA. Stats counters under MEM_ARB_STATS_EN.
module mips_mem_arbiter import mips_arb_pkg::*; #(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int CNT_W  = ARB_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_active,
  input  logic [ADDR_W-1:0] instr_address,
  output logic [DATA_W-1:0] instr_readdata,
  input  logic [ADDR_W-1:0] data_address,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [DATA_W-1:0] data_writedata,
  output logic [DATA_W-1:0] data_readdata,
  output logic              clk_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_waitrequest,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  instr_retired
);

  arb_state_t state, state_nxt;
  // Access kind captured in DECODE; a store takes priority over a load.
  logic       op_wr;

  // State register and DECODE-time capture of the access kind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == DECODE)
        op_wr <= data_write;
    end
  end

  // Capture instruction and load data on the cycle memory accepts the request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_readdata <= '0;
      data_readdata  <= '0;
    end else begin
      if ((state == FETCH) && !mem_waitrequest)
        instr_readdata <= mem_readdata;
      if ((state == DATA) && !mem_waitrequest && !op_wr)
        data_readdata <= mem_readdata;
    end
  end

  // Next-state and memory/commit outputs; the core is frozen until clk_enable,
  // so its address/data inputs stay stable while a request waits.
  always_comb begin
    state_nxt     = state;
    clk_enable    = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state)
      IDLE: begin
        if (cpu_active)
          state_nxt = FETCH;
      end
      FETCH: begin
        mem_read    = 1'b1;
        mem_address = instr_address;
        if (!mem_waitrequest)
          state_nxt = DECODE;
      end
      DECODE: begin
        state_nxt = (data_read || data_write) ? DATA : COMMIT;
      end
      DATA: begin
        mem_address = data_address;
        if (op_wr) begin
          mem_write     = 1'b1;
          mem_writedata = data_writedata;
        end else begin
          mem_read = 1'b1;
        end
        if (!mem_waitrequest)
          state_nxt = COMMIT;
      end
      COMMIT: begin
        clk_enable = 1'b1;
        state_nxt  = cpu_active ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_ARB_STATS_EN
  logic inc_stall;
  logic inc_retire;

  assign inc_stall  = (state != IDLE) && !clk_enable;
  assign inc_retire = clk_enable;

  mips_arb_stats #(.CNT_W(CNT_W)) u_stats (
    .clk           (clk),
    .rst_n         (reset),
    .inc_stall     (inc_stall),
    .inc_retire    (inc_retire),
    .stall_cycles  (stall_cycles),
    .instr_retired (instr_retired)
  );
`else
  assign stall_cycles  = '0;
  assign instr_retired = '0;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter against a per-instruction cycle timeline model.
// Latency: n/a.
// Backpressure: random mem_waitrequest stretches in FETCH and DATA.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_active;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;
  logic        clk_enable;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic [31:0] stall_cycles;
  logic [31:0] instr_retired;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: last fetched word, last loaded word, expected counter values.
  logic [31:0] exp_instr;
  logic [31:0] exp_drd;
  int          exp_stall;
  int          exp_ret;

  always #5 clk = ~clk;

  mips_mem_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_active      (cpu_active),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .data_address    (data_address),
    .data_read       (data_read),
    .data_write      (data_write),
    .data_writedata  (data_writedata),
    .data_readdata   (data_readdata),
    .clk_enable      (clk_enable),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest),
    .stall_cycles    (stall_cycles),
    .instr_retired   (instr_retired)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Sits in IDLE for n_idle cycles with the core halted, then raises cpu_active
  // so the arbiter is in FETCH at return.
  task automatic go_fetch(input int n_idle);
    for (int i = 0; i <= n_idle; i++) begin
      cpu_active      = (i == n_idle);
      mem_waitrequest = 1'($urandom);
      instr_address   = $urandom;
      #1;
      n_cmp++;
      if ({clk_enable, mem_read, mem_write, mem_address, mem_writedata} !== 67'd0) begin
        n_err++;
        $display("FAIL idle_quiet: got ce/rd/wr %b%b%b addr %h wd %h, required all zero",
                 clk_enable, mem_read, mem_write, mem_address, mem_writedata);
      end
      @(negedge clk);
    end
  endtask

  // Runs one instruction starting in its first FETCH cycle: wf/wd waitrequest
  // cycles in FETCH/DATA, act_after is cpu_active seen at COMMIT.
  task automatic do_instr(input logic [31:0] ia, input logic [31:0] iw,
                          input bit rd, input bit wr,
                          input logic [31:0] da, input logic [31:0] dw,
                          input logic [31:0] ld, input int wf, input int wd,
                          input bit act_after);
    int es;
    int er;
    // Before DECODE the core's decode outputs are stale; drive garbage there.
    instr_address  = ia;
    data_read      = 1'($urandom);
    data_write     = 1'($urandom);
    data_address   = $urandom;
    data_writedata = $urandom;
    for (int c = 0; c <= wf; c++) begin
      cpu_active      = 1'($urandom);
      mem_waitrequest = (c < wf);
      mem_readdata    = (c < wf) ? $urandom : iw;
      #1;
      n_cmp++;
      if ({mem_read, mem_write, clk_enable, mem_address} !== {3'b100, ia}) begin
        n_err++;
        $display("FAIL fetch_req cyc %0d: got rd/wr/ce %b%b%b addr %h, required 100 addr %h",
                 c, mem_read, mem_write, clk_enable, mem_address, ia);
      end
      n_cmp++;
      if (instr_readdata !== exp_instr) begin
        n_err++;
        $display("FAIL fetch_hold_instr cyc %0d: got %h, required %h", c, instr_readdata, exp_instr);
      end
      @(negedge clk);
    end
    exp_instr = iw;
    exp_stall += wf + 1;

    // DECODE: core now presents the real access request.
    data_read       = rd;
    data_write      = wr;
    data_address    = da;
    data_writedata  = dw;
    cpu_active      = 1'($urandom);
    mem_waitrequest = 1'($urandom);
    mem_readdata    = $urandom;
    #1;
    n_cmp++;
    if (instr_readdata !== iw) begin
      n_err++;
      $display("FAIL decode_instr: got %h, required %h", instr_readdata, iw);
    end
    n_cmp++;
    if ({clk_enable, mem_read, mem_write, mem_address, mem_writedata} !== 67'd0) begin
      n_err++;
      $display("FAIL decode_quiet: got ce/rd/wr %b%b%b addr %h wd %h, required all zero",
               clk_enable, mem_read, mem_write, mem_address, mem_writedata);
    end
    @(negedge clk);
    exp_stall += 1;

    if (rd || wr) begin
      for (int c = 0; c <= wd; c++) begin
        cpu_active      = 1'($urandom);
        mem_waitrequest = (c < wd);
        mem_readdata    = (c < wd) ? $urandom : ld;
        #1;
        n_cmp++;
        if ({mem_read, mem_write, clk_enable, mem_address} !== {!wr, wr, 1'b0, da}) begin
          n_err++;
          $display("FAIL data_req cyc %0d: got rd/wr/ce %b%b%b addr %h, required %b%b0 addr %h",
                   c, mem_read, mem_write, clk_enable, mem_address, !wr, wr, da);
        end
        if (wr) begin
          n_cmp++;
          if (mem_writedata !== dw) begin
            n_err++;
            $display("FAIL data_wdata cyc %0d: got %h, required %h", c, mem_writedata, dw);
          end
        end
        n_cmp++;
        if (data_readdata !== exp_drd) begin
          n_err++;
          $display("FAIL data_hold_rdata cyc %0d: got %h, required %h", c, data_readdata, exp_drd);
        end
        @(negedge clk);
      end
      if (rd && !wr) exp_drd = ld;
      exp_stall += wd + 1;
    end

    // COMMIT
    cpu_active      = act_after;
    mem_waitrequest = 1'($urandom);
    mem_readdata    = $urandom;
    #1;
    n_cmp++;
    if ({mem_read, mem_write, clk_enable, mem_address, mem_writedata} !== {3'b001, 64'd0}) begin
      n_err++;
      $display("FAIL commit_out: got rd/wr/ce %b%b%b addr %h wd %h, required 001 zeros",
               mem_read, mem_write, clk_enable, mem_address, mem_writedata);
    end
    n_cmp++;
    if ({instr_readdata, data_readdata} !== {exp_instr, exp_drd}) begin
      n_err++;
      $display("FAIL commit_regs: got instr %h data %h, required instr %h data %h",
               instr_readdata, data_readdata, exp_instr, exp_drd);
    end
`ifdef MEM_ARB_STATS_EN
    es = exp_stall;
    er = exp_ret;
`else
    es = 0;
    er = 0;
`endif
    n_cmp++;
    if ({stall_cycles, instr_retired} !== {32'(es), 32'(er)}) begin
      n_err++;
      $display("FAIL commit_counters: got stall %0d retired %0d, required stall %0d retired %0d",
               stall_cycles, instr_retired, es, er);
    end
    exp_ret++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset     = 1'b1;
    exp_instr = '0;
    exp_drd   = '0;
    exp_stall = 0;
    exp_ret   = 0;
  endtask

  task automatic test_reset();
    cpu_active      = 1'b1;
    instr_address   = 32'hBFC00000;
    data_read       = 1'b1;
    data_write      = 1'b1;
    data_address    = 32'h1234;
    data_writedata  = 32'h5678;
    mem_readdata    = 32'hFFFFFFFF;
    mem_waitrequest = 1'b0;
    reset           = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({clk_enable, mem_read, mem_write, mem_address, mem_writedata, instr_readdata,
         data_readdata, stall_cycles, instr_retired} !== 195'd0) begin
      n_err++;
      $display("FAIL reset_state: got ce/rd/wr %b%b%b addr %h instr %h data %h stall %0d ret %0d, required all zero",
               clk_enable, mem_read, mem_write, mem_address, instr_readdata, data_readdata,
               stall_cycles, instr_retired);
    end
    apply_reset();
    go_fetch(1);
  endtask

  task automatic test_alu();
    do_instr(32'hBFC00000, 32'h24080005, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1);
  endtask

  task automatic test_load_waits();
    do_instr(32'hBFC00004, 32'h8D090000, 1'b1, 1'b0, 32'h00002000, 32'h0,
             32'hDEADBEEF, 0, 2, 1'b1);
  endtask

  task automatic test_store();
    do_instr(32'hBFC00008, 32'hAD0A0000, 1'b0, 1'b1, 32'h00001000, 32'h12345678,
             32'hCAFEF00D, 0, 0, 1'b1);
  endtask

  task automatic test_both();
    do_instr(32'hBFC0000C, 32'h01234567, 1'b1, 1'b1, 32'h00003000, 32'hA5A5A5A5,
             32'h0BADBAD0, 1, 1, 1'b0);
  endtask

  task automatic test_reset_mid_fetch();
    go_fetch(2);
    instr_address   = 32'hBFC00010;
    mem_waitrequest = 1'b1;
    mem_readdata    = $urandom;
    cpu_active      = 1'b1;
    #1;
    n_cmp++;
    if ({mem_read, mem_address} !== {1'b1, 32'hBFC00010}) begin
      n_err++;
      $display("FAIL rst_pre_fetch: got rd %b addr %h, required 1 addr bfc00010", mem_read, mem_address);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({clk_enable, mem_read, mem_write, mem_address, mem_writedata, instr_readdata,
         data_readdata, stall_cycles, instr_retired} !== 195'd0) begin
      n_err++;
      $display("FAIL rst_async_abort: got ce/rd/wr %b%b%b addr %h instr %h data %h stall %0d ret %0d, required all zero",
               clk_enable, mem_read, mem_write, mem_address, instr_readdata, data_readdata,
               stall_cycles, instr_retired);
    end
    @(negedge clk);
    reset     = 1'b1;
    exp_instr = '0;
    exp_drd   = '0;
    exp_stall = 0;
    exp_ret   = 0;
    go_fetch(0);
    do_instr(32'hBFC00010, 32'h24420001, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 0, 1'b1);
  endtask

  task automatic test_stats();
    apply_reset();
    go_fetch(0);
    for (int i = 0; i < 3; i++)
      do_instr(32'hBFC00000 + 32'(4 * i), 32'h24080000 + 32'(i), 1'b0, 1'b0,
               32'h0, 32'h0, 32'h0, 0, 0, 1'b1);
    do_instr(32'hBFC0000C, 32'h8D0B0000, 1'b1, 1'b0, 32'h00000040, 32'h0,
             32'h13579BDF, 0, 0, 1'b0);
    cpu_active = 1'b0;
    #1;
    n_cmp++;
`ifdef MEM_ARB_STATS_EN
    if ({stall_cycles, instr_retired} !== {32'd9, 32'd4}) begin
      n_err++;
      $display("FAIL stats_totals: got stall %0d retired %0d, required stall 9 retired 4",
               stall_cycles, instr_retired);
    end
`else
    if ({stall_cycles, instr_retired} !== 64'd0) begin
      n_err++;
      $display("FAIL stats_disabled: got stall %0d retired %0d, required 0 and 0",
               stall_cycles, instr_retired);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_random();
    go_fetch(1);
    for (int i = 0; i < 60; i++) begin
      int  kind;
      bit  act;
      kind = $urandom_range(0, 3);
      act  = ($urandom_range(0, 3) != 0);
      do_instr({$urandom_range(0, 32'h3FFFFFFF), 2'b00}, $urandom,
               kind[0], kind[1], $urandom, $urandom, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), act);
      if (!act)
        go_fetch($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_waits();
    test_store();
    test_both();
    test_reset_mid_fetch();
    test_stats();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
